// File: rtl/dtree_pkg.sv
// Shared definitions for the arrhythmia decision-tree front end: default sizes,
// loader state encoding and the tree-input slot names.
package dtree_pkg;

  localparam int N_FEATURES_DEF = 36;
  localparam int FEAT_W_DEF     = 8;
  localparam int CLASS_W_DEF    = 5;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EVAL  = 2'd2,
    ST_HOLD  = 2'd3
  } loader_state_e;

  // Slot k of feat_vec carries tree input X<n>, ascending by original index.
  localparam int SLOT_X0   = 0;
  localparam int SLOT_X4   = 1;
  localparam int SLOT_X12  = 2;
  localparam int SLOT_X276 = N_FEATURES_DEF - 1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dtree_eval_timer.sv
// Down-counter that spaces class capture EVAL_CYCLES cycles after the
// feature vector completes, giving the combinational tree time to settle.
module dtree_eval_timer
  import dtree_pkg::*;
#(
  parameter int EVAL_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic run_i,
  output logic done_o
);

  localparam int CW = cnt_width(EVAL_CYCLES);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= CW'(EVAL_CYCLES - 1);
    end else if (run_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/dtree_feature_loader.sv
// Byte-stream loader that assembles the feature vector for the decision tree
// and returns its class over valid/ready. Define DTREE_LOADER_FRAME_CHECK_EN to enable s_last framing checks.
module dtree_feature_loader
  import dtree_pkg::*;
#(
  parameter int N_FEATURES  = N_FEATURES_DEF,
  parameter int FEAT_W      = FEAT_W_DEF,
  parameter int CLASS_W     = CLASS_W_DEF,
  parameter int EVAL_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [FEAT_W-1:0]            s_data,
  input  logic                         s_last,
  output logic [N_FEATURES*FEAT_W-1:0] feat_vec,
  input  logic [CLASS_W-1:0]           cls_in,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [CLASS_W-1:0]           m_class,
  output logic                         err_frame
);

  localparam int                CNT_W     = cnt_width(N_FEATURES);
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(N_FEATURES - 1);

  loader_state_e        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FEAT_W-1:0]    slot_q [N_FEATURES];
  logic                 m_valid_q, m_valid_d;
  logic [CLASS_W-1:0]   m_class_q, m_class_d;
  logic                 beat, at_end;
  logic                 timer_start, timer_done;

  assign s_ready = !rst && ((state_q == ST_LOAD) || (state_q == ST_DRAIN));
  assign beat    = s_valid && s_ready;
  assign at_end  = (cnt_q == LAST_SLOT);
  assign m_valid = m_valid_q;
  assign m_class = m_class_q;

`ifdef DTREE_LOADER_FRAME_CHECK_EN
  logic err_q, err_d;
  assign err_frame = err_q;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign err_frame     = 1'b0;
`endif

  dtree_eval_timer #(
    .EVAL_CYCLES(EVAL_CYCLES)
  ) u_eval_timer (
    .clk    (clk),
    .rst    (rst),
    .start_i(timer_start),
    .run_i  (state_q == ST_EVAL),
    .done_o (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    m_valid_d   = m_valid_q;
    m_class_d   = m_class_q;
    timer_start = 1'b0;
`ifdef DTREE_LOADER_FRAME_CHECK_EN
    err_d       = 1'b0;
`endif
    case (state_q)
      ST_LOAD: begin
        if (beat) begin
`ifdef DTREE_LOADER_FRAME_CHECK_EN
          if (s_last) begin
            cnt_d = '0;
            if (at_end) begin
              state_d     = ST_EVAL;
              timer_start = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (at_end) begin
            // Over-long frame: keep the first N bytes, swallow the rest.
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          if (at_end) begin
            cnt_d       = '0;
            state_d     = ST_EVAL;
            timer_start = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
`ifdef DTREE_LOADER_FRAME_CHECK_EN
      ST_DRAIN: begin
        if (beat && s_last) begin
          state_d = ST_LOAD;
        end
      end
`endif
      ST_EVAL: begin
        if (timer_done) begin
          m_class_d = cls_in;
          m_valid_d = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_class_q <= '0;
`ifdef DTREE_LOADER_FRAME_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_class_q <= m_class_d;
`ifdef DTREE_LOADER_FRAME_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  // Slots change only on LOAD beats, so the tree sees a frozen vector through EVAL/HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_FEATURES; k++) begin
        slot_q[k] <= '0;
      end
    end else if (beat && (state_q == ST_LOAD)) begin
      slot_q[cnt_q] <= s_data;
    end
  end

  for (genvar k = 0; k < N_FEATURES; k++) begin : g_pack
    assign feat_vec[FEAT_W*k +: FEAT_W] = slot_q[k];
  end

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Bench for dtree_feature_loader: frame-level reference model with per-cycle
// comparison plus directed literal checks. Honours DTREE_LOADER_FRAME_CHECK_EN.
module tb_dtree_feature_loader;

  localparam int NF = 36;
  localparam int FW = 8;
  localparam int CW = 5;
  localparam int EC = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid, s_ready, s_last;
  logic [FW-1:0]     s_data;
  logic [NF*FW-1:0]  feat_vec;
  logic [CW-1:0]     cls_in, m_class;
  logic              m_valid, m_ready, err_frame;

  always #5 clk = ~clk;

  dtree_feature_loader #(
    .N_FEATURES (NF),
    .FEAT_W     (FW),
    .CLASS_W    (CW),
    .EVAL_CYCLES(EC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .feat_vec (feat_vec),
    .cls_in   (cls_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_class  (m_class),
    .err_frame(err_frame)
  );

  // Stand-in classifier: low 5 bits of the sum of all features, xor 20.
  function automatic logic [CW-1:0] tree(input logic [NF*FW-1:0] v);
    int s;
    s = 0;
    for (int k = 0; k < NF; k++) s += int'(v[FW*k +: FW]);
    return CW'(s) ^ 5'd20;
  endfunction

  assign cls_in = tree(feat_vec);

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [NF*FW-1:0] act, input logic [NF*FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position, result pending, eval wait.
  logic [FW-1:0] exp_slot [NF] = '{default: '0};
  int            pos        = 0;
  int            eval_left  = 0;
  bit            accepting  = 1'b1;
  bit            draining   = 1'b0;
  bit            pending    = 1'b0;
  bit            exp_err    = 1'b0;
  bit            mdl_beat;
  logic [CW-1:0] exp_class  = '0;

  function automatic logic [NF*FW-1:0] pack_exp();
    logic [NF*FW-1:0] v;
    for (int k = 0; k < NF; k++) v[FW*k +: FW] = exp_slot[k];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NF; k++) exp_slot[k] = '0;
      pos = 0; eval_left = 0; accepting = 1'b1; draining = 1'b0;
      pending = 1'b0; exp_err = 1'b0; exp_class = '0;
    end else begin
      mdl_beat = s_valid && accepting;
      exp_err  = 1'b0;
      if (pending) begin
        if (m_ready) begin
          pending   = 1'b0;
          accepting = 1'b1;
        end
      end else if (eval_left > 0) begin
        eval_left--;
        if (eval_left == 0) begin
          pending   = 1'b1;
          exp_class = tree(pack_exp());
        end
      end else if (mdl_beat) begin
        if (draining) begin
          if (s_last) draining = 1'b0;
        end else begin
          exp_slot[pos] = s_data;
`ifdef DTREE_LOADER_FRAME_CHECK_EN
          if (pos == NF - 1 && s_last) begin
            pos = 0; accepting = 1'b0; eval_left = EC;
          end else if (s_last) begin
            exp_err = 1'b1; pos = 0;
          end else if (pos == NF - 1) begin
            exp_err = 1'b1; draining = 1'b1; pos = 0;
          end else begin
            pos++;
          end
`else
          if (pos == NF - 1) begin
            pos = 0; accepting = 1'b0; eval_left = EC;
          end else begin
            pos++;
          end
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("s_ready",   64'(s_ready),   64'(accepting && !rst));
    chk("m_valid",   64'(m_valid),   64'(pending));
    chk("m_class",   64'(m_class),   64'(exp_class));
    chk("err_frame", 64'(err_frame), 64'(exp_err));
    chk_vec("feat_vec", feat_vec, pack_exp());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [FW-1:0] d, input logic last);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!acc && guard < 50) begin
      acc = s_ready;
      tick();
      guard++;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL beat_accept: got no s_ready, expected acceptance of %0h", d);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int base, input int last_at, input bit gaps);
    for (int i = 1; i <= n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      send_beat(FW'(base + i), i == last_at);
    end
  endtask

  task automatic wait_result();
    int g;
    g = 0;
    while (!m_valid && g < 100) begin
      tick();
      g++;
    end
    chk("result_arrives", 64'(m_valid), 64'd1);
  endtask

  logic [NF*FW-1:0] ref_vec;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) tick();
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_class", 64'(m_class), 64'd0);
    chk("rst_err", 64'(err_frame), 64'd0);
    chk_vec("rst_feat", feat_vec, '0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 64'(s_ready), 64'd1);

    // Nominal frame, values 1..36
    m_ready = 1'b1;
    send_frame(36, 0, 36, 1'b0);
    chk("nom_ready_drop", 64'(s_ready), 64'd0);
    chk("nom_valid_early", 64'(m_valid), 64'd0);
    tick();
    chk("nom_valid_rise", 64'(m_valid), 64'd1);
    chk("nom_class", 64'(m_class), 64'd14);
    chk("nom_ready_low", 64'(s_ready), 64'd0);
    for (int k = 0; k < NF; k++) chk("nom_slot", 64'(feat_vec[FW*k +: FW]), 64'(k + 1));
    tick();
    chk("nom_valid_clear", 64'(m_valid), 64'd0);
    chk("nom_ready_back", 64'(s_ready), 64'd1);

    // Back-pressure, values 100..135 -> class 18
    m_ready = 1'b0;
    send_frame(36, 99, 36, 1'b0);
    wait_result();
    chk("bp_class", 64'(m_class), 64'd18);
    repeat (10) begin
      tick();
      chk("bp_valid_hold", 64'(m_valid), 64'd1);
      chk("bp_class_hold", 64'(m_class), 64'd18);
      chk("bp_ready_low", 64'(s_ready), 64'd0);
    end
    m_ready = 1'b1;
    tick();
    chk("bp_valid_clear", 64'(m_valid), 64'd0);
    chk("bp_ready_back", 64'(s_ready), 64'd1);

`ifdef DTREE_LOADER_FRAME_CHECK_EN
    // Short frame: s_last on beat 20
    send_frame(20, 0, 20, 1'b0);
    chk("short_err", 64'(err_frame), 64'd1);
    chk("short_ready", 64'(s_ready), 64'd1);
    tick();
    chk("short_err_once", 64'(err_frame), 64'd0);
    repeat (5) begin
      tick();
      chk("short_no_result", 64'(m_valid), 64'd0);
    end
    send_frame(36, 0, 36, 1'b0);
    wait_result();
    chk("short_next_class", 64'(m_class), 64'd14);
    tick();

    // Long frame: 40 beats of 201..240, only the first 36 kept
    send_frame(36, 200, 0, 1'b0);
    chk("long_err", 64'(err_frame), 64'd1);
    chk("long_drain_ready", 64'(s_ready), 64'd1);
    for (int i = 37; i <= 40; i++) send_beat(FW'(200 + i), i == 40);
    chk("long_err_clear", 64'(err_frame), 64'd0);
    chk("long_ready", 64'(s_ready), 64'd1);
    repeat (3) begin
      tick();
      chk("long_no_result", 64'(m_valid), 64'd0);
    end
    chk("long_slot0", 64'(feat_vec[7:0]), 64'd201);
    chk("long_slot35", 64'(feat_vec[FW*35 +: FW]), 64'd236);
`else
    // s_last on beat 20 is ignored; the frame still runs 36 beats
    send_frame(36, 0, 20, 1'b0);
    chk("nolast_err", 64'(err_frame), 64'd0);
    wait_result();
    chk("nolast_class", 64'(m_class), 64'd14);
    tick();
`endif

    // Asynchronous reset while beat 17 is offered
    m_ready = 1'b1;
    send_frame(16, 49, 0, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'd66;
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 64'(s_ready), 64'd0);
    chk("arst_valid", 64'(m_valid), 64'd0);
    chk("arst_class", 64'(m_class), 64'd0);
    chk("arst_err", 64'(err_frame), 64'd0);
    chk_vec("arst_feat", feat_vec, '0);
    s_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    send_frame(36, 0, 36, 1'b0);
    tick();
    chk("arst_next_valid", 64'(m_valid), 64'd1);
    chk("arst_next_class", 64'(m_class), 64'd14);
    chk("arst_next_slot0", 64'(feat_vec[7:0]), 64'd1);
    tick();

    // Reset while a result is held
    m_ready = 1'b0;
    send_frame(36, 99, 36, 1'b0);
    wait_result();
    #2 rst = 1'b1;
    #1;
    chk("hold_rst_valid", 64'(m_valid), 64'd0);
    chk("hold_rst_class", 64'(m_class), 64'd0);
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    tick();
    chk("hold_rst_ready", 64'(s_ready), 64'd1);
    chk("hold_rst_lost", 64'(m_valid), 64'd0);

    // Bubbles: same frame with random idle gaps
    send_frame(36, 0, 36, 1'b1);
    wait_result();
    chk("bub_class", 64'(m_class), 64'd14);
    for (int k = 0; k < NF; k++) ref_vec[FW*k +: FW] = FW'(k + 1);
    chk_vec("bub_feat", feat_vec, ref_vec);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no completion, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
